// File: rtl/instr_register.sv
// Opcode/flags register pair plus the BOOT/RUN/HALT sequencer that gates the
// microcode control stage (ctrlen) and clears its step counters (step_reset).
module instr_register #(
   parameter int unsigned BOOT_CYCLES = 4
) (
   input  logic       iclk,
   input  logic       rst,
   input  logic [7:0] bus_in,
   input  logic       ir_load,
   input  logic [3:0] alu_flags,
   input  logic       fl_load,
   input  logic       fl_clc,
   input  logic       instr_end,
   input  logic       halt,
   input  logic       resume,
   output logic [7:0] opcode,
   output logic [3:0] flags,
   output logic       ctrlen,
   output logic       step_reset,
   output logic       halted
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] opcode_q, opcode_d;
   logic [3:0] flags_q, flags_d;
   logic       ctrlen_q, ctrlen_d;
   logic       halted_q, halted_d;

   always_ff @(posedge iclk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_BOOT;
         cnt_q    <= 4'h0;
         opcode_q <= 8'h00;
         flags_q  <= 4'h0;
         ctrlen_q <= 1'b1;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         opcode_q <= opcode_d;
         flags_q  <= flags_d;
         ctrlen_q <= ctrlen_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      opcode_d = opcode_q;
      flags_d  = flags_q;
      case (state_q)
         ST_BOOT: begin
            if (cnt_q == BOOT_LAST) begin
               state_d = ST_RUN;
               cnt_d   = 4'h0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_RUN: begin
            if (ir_load) opcode_d = bus_in;
            if (fl_load) flags_d = alu_flags;
            // Carry clear overrides a simultaneous flags load on bit 0 only.
            if (fl_clc) flags_d[0] = 1'b0;
            if (halt) state_d = ST_HALT;
         end
         ST_HALT: begin
            if (resume) state_d = ST_RUN;
         end
         default: begin
            state_d = ST_BOOT;
            cnt_d   = 4'h0;
         end
      endcase
      // Output flags follow the next state so they switch on the same edge.
      ctrlen_d = (state_d != ST_RUN);
      halted_d = (state_d == ST_HALT);
   end

   assign opcode     = opcode_q;
   assign flags      = flags_q;
   assign ctrlen     = ctrlen_q;
   assign halted     = halted_q;
   assign step_reset = (state_q == ST_RUN) && !instr_end;

endmodule

// File: tb/tb_instr_register.sv
// Directed-vector bench: the stimulus pushes expected outputs into a queue and a
// negedge monitor pops and compares them against the DUT.
module tb_instr_register;

   logic       iclk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] bus_in = 8'h00;
   logic       ir_load = 1'b0;
   logic [3:0] alu_flags = 4'h0;
   logic       fl_load = 1'b0;
   logic       fl_clc = 1'b0;
   logic       instr_end = 1'b0;
   logic       halt = 1'b0;
   logic       resume = 1'b0;
   logic [7:0] opcode;
   logic [3:0] flags;
   logic       ctrlen;
   logic       step_reset;
   logic       halted;

   instr_register #(.BOOT_CYCLES(4)) dut (
      .iclk(iclk), .rst(rst), .bus_in(bus_in), .ir_load(ir_load),
      .alu_flags(alu_flags), .fl_load(fl_load), .fl_clc(fl_clc),
      .instr_end(instr_end), .halt(halt), .resume(resume),
      .opcode(opcode), .flags(flags), .ctrlen(ctrlen),
      .step_reset(step_reset), .halted(halted)
   );

   always #5 iclk = ~iclk;

   typedef struct {
      string      name;
      logic [7:0] op;
      logic [3:0] fl;
      logic       ce;
      logic       sr;
      logic       hl;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Monitor: outputs are sampled mid-cycle, away from the rising edge.
   always @(negedge iclk) begin
      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_vec++;
         if (opcode !== e.op || flags !== e.fl || ctrlen !== e.ce ||
             step_reset !== e.sr || halted !== e.hl) begin
            n_bad++;
            $display("FAIL %s: got op=%h fl=%h ce=%b sr=%b hl=%b, want op=%h fl=%h ce=%b sr=%b hl=%b",
                     e.name, opcode, flags, ctrlen, step_reset, halted,
                     e.op, e.fl, e.ce, e.sr, e.hl);
         end else begin
            $display("ok   %s: op=%h fl=%h ce=%b sr=%b hl=%b",
                     e.name, opcode, flags, ctrlen, step_reset, halted);
         end
      end
   end

   // Drive one cycle's inputs just after the rising edge and queue the outputs
   // expected at mid-cycle: registered values reflect the previous vector's
   // inputs, step_reset reflects this vector's instr_end.
   task automatic vec(input string nm, input logic r,
                      input logic irl, input logic [7:0] b,
                      input logic fll, input logic [3:0] af, input logic clc,
                      input logic ie, input logic h, input logic rs,
                      input logic [7:0] e_op, input logic [3:0] e_fl,
                      input logic e_ce, input logic e_sr, input logic e_hl);
      exp_t e;
      @(posedge iclk);
      #1;
      rst = r; ir_load = irl; bus_in = b; fl_load = fll; alu_flags = af;
      fl_clc = clc; instr_end = ie; halt = h; resume = rs;
      e.name = nm; e.op = e_op; e.fl = e_fl; e.ce = e_ce; e.sr = e_sr; e.hl = e_hl;
      exp_q.push_back(e);
   endtask

   initial begin
      //   name        rst irl bus    fll alu   clc ie  h   rs   op     fl    ce sr hl
      vec("reset",     0, 0, 8'h00, 0, 4'h0, 0, 0, 0, 0,  8'h00, 4'h0, 1, 0, 0);
      vec("boot1",     0, 1, 8'hFF, 1, 4'hF, 0, 0, 0, 0,  8'h00, 4'h0, 1, 0, 0);
      vec("boot2",     0, 1, 8'hFF, 1, 4'hF, 0, 1, 1, 0,  8'h00, 4'h0, 1, 0, 0);
      vec("boot3",     0, 1, 8'hFF, 1, 4'hF, 0, 0, 0, 0,  8'h00, 4'h0, 1, 0, 0);
      vec("run_entry", 0, 0, 8'h00, 0, 4'h0, 0, 0, 0, 0,  8'h00, 4'h0, 0, 1, 0);
      vec("ld_a5",     0, 1, 8'hA5, 0, 4'h0, 0, 0, 0, 0,  8'h00, 4'h0, 0, 1, 0);
      vec("op_a5",     0, 0, 8'h3C, 0, 4'h0, 0, 0, 0, 0,  8'hA5, 4'h0, 0, 1, 0);
      vec("op_hold",   0, 0, 8'h3C, 1, 4'hF, 1, 0, 0, 0,  8'hA5, 4'h0, 0, 1, 0);
      vec("fl_prio",   0, 0, 8'h3C, 0, 4'hF, 1, 0, 0, 0,  8'hA5, 4'hE, 0, 1, 0);
      vec("clc_only",  0, 0, 8'h00, 1, 4'h3, 0, 0, 0, 0,  8'hA5, 4'hE, 0, 1, 0);
      vec("fl_load",   0, 0, 8'h00, 0, 4'h0, 1, 0, 0, 0,  8'hA5, 4'h3, 0, 1, 0);
      vec("iend_hi",   0, 0, 8'h00, 0, 4'h0, 0, 1, 0, 0,  8'hA5, 4'h2, 0, 0, 0);
      vec("iend_lo",   0, 0, 8'h00, 0, 4'h0, 0, 0, 0, 0,  8'hA5, 4'h2, 0, 1, 0);
      vec("halt_req",  0, 1, 8'h7F, 0, 4'h0, 0, 0, 1, 0,  8'hA5, 4'h2, 0, 1, 0);
      vec("halted",    0, 0, 8'h00, 1, 4'h9, 0, 1, 0, 0,  8'h7F, 4'h2, 1, 0, 1);
      vec("halt_fl",   0, 1, 8'h11, 0, 4'h0, 0, 0, 1, 0,  8'h7F, 4'h2, 1, 0, 1);
      vec("halt_op",   0, 0, 8'h00, 0, 4'h0, 0, 0, 0, 1,  8'h7F, 4'h2, 1, 0, 1);
      vec("resumed",   0, 0, 8'h00, 0, 4'h0, 0, 0, 0, 0,  8'h7F, 4'h2, 0, 1, 0);
      vec("run_resume",0, 1, 8'h42, 0, 4'h0, 0, 0, 0, 1,  8'h7F, 4'h2, 0, 1, 0);
      vec("op_42",     0, 0, 8'h00, 0, 4'h0, 0, 0, 0, 0,  8'h42, 4'h2, 0, 1, 0);
      vec("async_rst", 1, 0, 8'h00, 0, 4'h0, 0, 0, 0, 0,  8'h00, 4'h0, 1, 0, 0);
      vec("rst_rel",   0, 0, 8'h00, 0, 4'h0, 0, 0, 0, 0,  8'h00, 4'h0, 1, 0, 0);
      vec("reboot1",   0, 1, 8'hEE, 0, 4'h0, 0, 0, 0, 0,  8'h00, 4'h0, 1, 0, 0);
      vec("reboot2",   0, 0, 8'h00, 0, 4'h0, 0, 0, 0, 0,  8'h00, 4'h0, 1, 0, 0);
      vec("reboot3",   0, 0, 8'h00, 0, 4'h0, 0, 0, 0, 0,  8'h00, 4'h0, 1, 0, 0);
      vec("rerun",     0, 0, 8'h00, 0, 4'h0, 0, 0, 0, 0,  8'h00, 4'h0, 0, 1, 0);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge iclk);
      if (exp_q.size() > 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending checks, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_register.md
# instr_register

Instruction/flags register and run-state sequencer feeding the microcode control stage. Latches the opcode from the data bus and the ALU flags into registers that drive the control stage's `opcode` and `flags` inputs. A BOOT/RUN/HALT state machine produces the control stage's `ctrlen` (active-low output enable) and `step_reset` (active-low step-counter clear) signals, so microcode is released only after a clean power-on sequence and can be frozen by a halt instruction.

## Interface
Parameters:
- `BOOT_CYCLES`, 4: cycles held in BOOT after reset release; legal range 1..15.

Ports:
- Clock and reset: one clock `iclk`; reset `rst` is asynchronous and active-high.
- `iclk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset.
- `bus_in`  in  8  data bus, opcode source.
- `ir_load`  in  1  control-word bit; latch `bus_in` into the opcode register.
- `alu_flags`  in  4  flags from the ALU: {V,N,Z,C} = bits [3:0].
- `fl_load`  in  1  control-word bit; latch `alu_flags`.
- `fl_clc`  in  1  control-word bit; clear carry (`flags[0]`).
- `instr_end`  in  1  control-word bit; final microstep of the instruction.
- `halt`  in  1  control-word bit; enter HALT.
- `resume`  in  1  external run request (front-panel pulse, synchronous to `iclk`).
- `opcode`  out  8  opcode register.
- `flags`  out  4  flags register.
- `ctrlen`  out  1  0 = control word driven, 1 = released (high-Z).
- `step_reset`  out  1  active-low; 0 clears the step counters on the next edge.
- `halted`  out  1  1 while in HALT.

## Operation
- States: BOOT, RUN, HALT (2-bit encoding), plus a 4-bit boot counter.
- Reset (asynchronous): state=BOOT, counter=0, `opcode`=8'h00, `flags`=4'h0, `ctrlen`=1, `step_reset`=0, `halted`=0. All outputs are registered except `step_reset`.
- BOOT:
  - The counter increments every cycle.
  - When the counter reaches `BOOT_CYCLES`-1, the next state is RUN.
  - All data-path load inputs are ignored.
- RUN:
  - `ctrlen`=0.
  - `step_reset` = ~`instr_end` (combinational), so the counters restart at step 0 on the edge that ends an instruction.
  - `ir_load`=1: `opcode` <= `bus_in`.
  - `fl_load`=1: `flags` <= `alu_flags`.
  - `fl_clc`=1: `flags[0]` <= 0. If asserted together with `fl_load`, `fl_clc` wins for bit 0 only.
  - `halt`=1: next state is HALT. Loads asserted on the same edge still take effect.
- HALT:
  - `ctrlen`=1, `step_reset`=0, `halted`=1.
  - The opcode and flags registers hold.
  - `resume`=1: next state is RUN. Resume restarts at step 0 with the held opcode.
- `halt` in BOOT or HALT is ignored. `resume` in BOOT or RUN is ignored.
- `rst` asserted in any state, mid-instruction included, forces the reset values immediately, with no wait for `iclk`.

## Timing
- After `rst` deasserts: `ctrlen` goes 0 on the edge that ends cycle `BOOT_CYCLES`. That is, for `BOOT_CYCLES`=4, `ctrlen` falls on the 4th rising edge after release.
- `step_reset` is 0 throughout BOOT. It rises in the same cycle `ctrlen` falls.
- Opcode and flags loads have 1-cycle latency: the value sampled on edge N is visible after edge N.
- `halt` sampled on edge N gives `ctrlen`=1, `halted`=1, `step_reset`=0 after edge N.
- `resume` sampled on edge M gives `ctrlen`=0, `halted`=0 after edge M. The step counter is at 0 in that cycle because it was held clear during HALT.
- Only `step_reset` has a combinational path from inputs (`instr_end`). There are no other input-to-output combinational paths.

## Test plan
- Boot sequence: pulse `rst`, release; with `BOOT_CYCLES`=4 -> `ctrlen`=1 and `step_reset`=0 for 4 edges, then `ctrlen`=0, `step_reset`=1, `opcode`=8'h00, `flags`=4'h0.
- Opcode load: in RUN, `bus_in`=8'hA5, `ir_load`=1 for one edge -> `opcode`=8'hA5 next cycle; drive `bus_in`=8'h3C with `ir_load`=0 -> `opcode` stays 8'hA5.
- Flags priority: `alu_flags`=4'hF with `fl_load`=1 and `fl_clc`=1 on the same edge -> `flags`=4'hE; then `fl_clc` alone -> carry stays 0.
- Instruction end: `instr_end`=1 -> `step_reset`=0 in the same cycle; `instr_end`=0 -> `step_reset`=1.
- Halt/resume: `halt` and `ir_load` with `bus_in`=8'h7F on the same edge -> `opcode`=8'h7F, `halted`=1, `ctrlen`=1. A `fl_load` during HALT leaves `flags` unchanged. A `resume` pulse -> `ctrlen`=0, `halted`=0 next cycle.
- Mid-operation reset: assert `rst` asynchronously between edges while in RUN with `opcode`=8'h42 -> `opcode`=8'h00, `ctrlen`=1, `step_reset`=0 immediately; the boot sequence repeats after release.
